// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives instruction memory and
// registers each fetched word into the IF/ID stage for decode.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_BYTES   = 128,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic [31:0] IAddr,
    input  logic [31:0] IDataIn,
    input  logic        Stall,
    input  logic        RedirectValid,
    input  logic [31:0] RedirectAddr,
    output logic [31:0] IR,
    output logic [31:0] PCOut,
    output logic [31:0] PCPlus4Out,
    output logic        IFValid,
    output logic        Halted,
    output logic        Fault,
    output logic [31:0] FetchCount
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        HALT  = 2'b01,
        FAULT = 2'b10
    } mode_t;

    localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    mode_t       mode;
    mode_t       mode_nxt;

    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic [31:0] ir;
    logic [31:0] ir_nxt;
    logic [31:0] pc_out;
    logic [31:0] pc_out_nxt;
    logic [31:0] pc_plus4;
    logic [31:0] pc_plus4_nxt;
    logic        valid;
    logic        valid_nxt;
    logic        halted;
    logic        halted_nxt;
    logic        fault;
    logic        fault_nxt;
    logic [31:0] count;
    logic [31:0] count_nxt;

    logic [31:0] pc_inc;
    logic        out_of_range;
    logic        is_halt;

    assign pc_inc       = pc + 32'd4;
    assign out_of_range = (pc > LAST_ADDR);
    assign is_halt      = (IDataIn[31:26] == HALT_OPCODE);

    // State register for mode and the IF/ID stage; reset wins over all
    always_ff @(posedge CLK) begin
        if (Reset) begin
            mode     <= RUN;
            pc       <= RESET_PC & WORD_MASK;
            ir       <= '0;
            pc_out   <= '0;
            pc_plus4 <= '0;
            valid    <= 1'b0;
            halted   <= 1'b0;
            fault    <= 1'b0;
            count    <= '0;
        end else begin
            mode     <= mode_nxt;
            pc       <= pc_nxt;
            ir       <= ir_nxt;
            pc_out   <= pc_out_nxt;
            pc_plus4 <= pc_plus4_nxt;
            valid    <= valid_nxt;
            halted   <= halted_nxt;
            fault    <= fault_nxt;
            count    <= count_nxt;
        end
    end

    // Next-state: redirect > stall > range fault > halt > sequential fetch
    always_comb begin
        mode_nxt     = mode;
        pc_nxt       = pc;
        ir_nxt       = ir;
        pc_out_nxt   = pc_out;
        pc_plus4_nxt = pc_plus4;
        valid_nxt    = valid;
        halted_nxt   = halted;
        fault_nxt    = fault;
        count_nxt    = count;

        unique case (mode)
            RUN: begin
                if (RedirectValid) begin
                    pc_nxt    = RedirectAddr & WORD_MASK;
                    ir_nxt    = '0;
                    valid_nxt = 1'b0;
                end else if (Stall) begin
                    // whole stage holds
                end else if (out_of_range) begin
                    ir_nxt    = '0;
                    valid_nxt = 1'b0;
                    fault_nxt = 1'b1;
                    mode_nxt  = FAULT;
                end else begin
                    ir_nxt       = IDataIn;
                    pc_out_nxt   = pc;
                    pc_plus4_nxt = pc_inc;
                    valid_nxt    = 1'b1;
                    count_nxt    = count + 32'd1;
                    if (is_halt) begin
                        halted_nxt = 1'b1;
                        mode_nxt   = HALT;
                    end else begin
                        pc_nxt = pc_inc;
                    end
                end
            end
            HALT: begin
                // present the halt word until decode accepts it once
                if (!Stall) begin
                    valid_nxt = 1'b0;
                end
            end
            FAULT: begin
                valid_nxt = 1'b0;
            end
            default: begin
                mode_nxt = FAULT;
            end
        endcase
    end

    assign IAddr      = pc;
    assign IR         = ir;
    assign PCOut      = pc_out;
    assign PCPlus4Out = pc_plus4;
    assign IFValid    = valid;
    assign Halted     = halted;
    assign Fault      = fault;
    assign FetchCount = count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed scenarios with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_instr_fetch_unit;

    logic        CLK;
    logic        Reset;
    logic [31:0] IAddr;
    logic [31:0] IDataIn;
    logic        Stall;
    logic        RedirectValid;
    logic [31:0] RedirectAddr;
    logic [31:0] IR;
    logic [31:0] PCOut;
    logic [31:0] PCPlus4Out;
    logic        IFValid;
    logic        Halted;
    logic        Fault;
    logic [31:0] FetchCount;

    localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    logic [31:0] mem [32];

    // model state
    logic [31:0] m_pc, m_ir, m_pco, m_pc4, m_cnt, m_w;
    logic        m_v, m_h, m_f;

    instr_fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .MEM_BYTES   (128),
        .HALT_OPCODE (6'b111111)
    ) dut (
        .CLK           (CLK),
        .Reset         (Reset),
        .IAddr         (IAddr),
        .IDataIn       (IDataIn),
        .Stall         (Stall),
        .RedirectValid (RedirectValid),
        .RedirectAddr  (RedirectAddr),
        .IR            (IR),
        .PCOut         (PCOut),
        .PCPlus4Out    (PCPlus4Out),
        .IFValid       (IFValid),
        .Halted        (Halted),
        .Fault         (Fault),
        .FetchCount    (FetchCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a < 32'd128) return mem[a[6:2]];
        return 32'hDEAD_BEEF;
    endfunction

    assign IDataIn = word_at(IAddr);

    function automatic logic [31:0] wdef(input int i);
        return 32'h0400_0000 + 32'(i) * 32'h11;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // behavioural model: one step per rising edge
    always @(posedge CLK) begin
        if (Reset) begin
            m_pc = 0; m_ir = 0; m_pco = 0; m_pc4 = 0;
            m_cnt = 0; m_v = 0; m_h = 0; m_f = 0;
        end else if (m_h) begin
            if (!Stall) m_v = 0;
        end else if (m_f) begin
            m_v = 0;
        end else if (RedirectValid) begin
            m_pc = {RedirectAddr[31:2], 2'b00};
            m_ir = 0;
            m_v  = 0;
        end else if (Stall) begin
            m_v = m_v;
        end else if (m_pc > 32'd124) begin
            m_ir = 0;
            m_v  = 0;
            m_f  = 1;
        end else begin
            m_w   = word_at(m_pc);
            m_ir  = m_w;
            m_pco = m_pc;
            m_pc4 = m_pc + 4;
            m_v   = 1;
            m_cnt = m_cnt + 1;
            if (m_w[31:26] == 6'b111111) m_h = 1;
            else m_pc = m_pc + 4;
        end
    end

    // compare DUT against model shortly after each edge
    always @(posedge CLK) begin
        #1;
        if (chk_en) begin
            chk("model IAddr", IAddr, m_pc);
            chk("model IR", IR, m_ir);
            chk("model PCOut", PCOut, m_pco);
            chk("model PCPlus4Out", PCPlus4Out, m_pc4);
            chk("model IFValid", 32'(IFValid), 32'(m_v));
            chk("model Halted", 32'(Halted), 32'(m_h));
            chk("model Fault", 32'(Fault), 32'(m_f));
            chk("model FetchCount", FetchCount, m_cnt);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        cyc(1);
        Reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = wdef(i);
        Reset         = 1'b1;
        Stall         = 1'b0;
        RedirectValid = 1'b0;
        RedirectAddr  = '0;
        cyc(2);
        chk_en = 1;

        // reset state
        chk("rst IR", IR, 32'h0);
        chk("rst IFValid", 32'(IFValid), 32'h0);
        chk("rst FetchCount", FetchCount, 32'h0);
        chk("rst IAddr", IAddr, 32'h0);
        chk("rst Halted", 32'(Halted), 32'h0);
        chk("rst Fault", 32'(Fault), 32'h0);

        // sequential fetch
        Reset = 1'b0;
        cyc(1);
        chk("seq1 IR", IR, 32'h0400_0000);
        chk("seq1 PCOut", PCOut, 32'h0);
        cyc(1);
        chk("seq2 IR", IR, 32'h0400_0011);
        chk("seq2 PCOut", PCOut, 32'h4);
        chk("seq2 PCPlus4Out", PCPlus4Out, 32'h8);
        cyc(1);
        chk("seq3 IR", IR, 32'h0400_0022);
        chk("seq3 PCOut", PCOut, 32'h8);
        chk("seq3 IFValid", 32'(IFValid), 32'h1);
        chk("seq3 FetchCount", FetchCount, 32'd3);

        // stall while IR holds W1
        do_reset();
        cyc(2);
        Stall = 1'b1;
        cyc(2);
        chk("stall IR", IR, 32'h0400_0011);
        chk("stall PCOut", PCOut, 32'h4);
        chk("stall IAddr", IAddr, 32'h8);
        chk("stall FetchCount", FetchCount, 32'd2);
        Stall = 1'b0;
        cyc(1);
        chk("unstall IR", IR, 32'h0400_0022);
        chk("unstall PCOut", PCOut, 32'h8);

        // redirect to an unaligned target
        do_reset();
        cyc(2);
        RedirectValid = 1'b1;
        RedirectAddr  = 32'h0000_002E;
        cyc(1);
        RedirectValid = 1'b0;
        chk("redir IFValid", 32'(IFValid), 32'h0);
        chk("redir IR", IR, 32'h0);
        chk("redir IAddr", IAddr, 32'h2C);
        cyc(1);
        chk("redir2 IR", IR, 32'h0400_00BB);
        chk("redir2 PCOut", PCOut, 32'h2C);

        // redirect beats stall and halt
        do_reset();
        mem[0]        = HALT_WORD;
        Stall         = 1'b1;
        RedirectValid = 1'b1;
        RedirectAddr  = 32'h20;
        cyc(1);
        Stall         = 1'b0;
        RedirectValid = 1'b0;
        chk("rbsh IAddr", IAddr, 32'h20);
        chk("rbsh Halted", 32'(Halted), 32'h0);
        chk("rbsh IFValid", 32'(IFValid), 32'h0);
        mem[0] = wdef(0);

        // halt at 0x10, stalled once while presented
        do_reset();
        mem[4] = HALT_WORD;
        cyc(5);
        chk("halt IR", IR, HALT_WORD);
        chk("halt IFValid", 32'(IFValid), 32'h1);
        chk("halt Halted", 32'(Halted), 32'h1);
        chk("halt FetchCount", FetchCount, 32'd5);
        Stall = 1'b1;
        cyc(1);
        chk("halt stall IFValid", 32'(IFValid), 32'h1);
        Stall = 1'b0;
        cyc(1);
        chk("halt drop IFValid", 32'(IFValid), 32'h0);
        chk("halt IAddr", IAddr, 32'h10);
        RedirectValid = 1'b1;
        RedirectAddr  = 32'h40;
        cyc(2);
        RedirectValid = 1'b0;
        chk("halt redir IAddr", IAddr, 32'h10);
        chk("halt redir IR", IR, HALT_WORD);
        mem[4] = wdef(4);

        // last valid word, then fault at 0x80
        do_reset();
        cyc(2);
        RedirectValid = 1'b1;
        RedirectAddr  = 32'h7C;
        cyc(1);
        RedirectValid = 1'b0;
        cyc(1);
        chk("edge IR", IR, wdef(31));
        chk("edge IFValid", 32'(IFValid), 32'h1);
        chk("edge IAddr", IAddr, 32'h80);
        chk("edge Fault", 32'(Fault), 32'h0);
        cyc(1);
        chk("fault1 Fault", 32'(Fault), 32'h1);
        chk("fault1 IFValid", 32'(IFValid), 32'h0);
        chk("fault1 FetchCount", FetchCount, 32'd3);

        // direct redirect into fault, then reset recovery
        do_reset();
        cyc(2);
        RedirectValid = 1'b1;
        RedirectAddr  = 32'h80;
        cyc(1);
        RedirectValid = 1'b0;
        chk("fault IAddr", IAddr, 32'h80);
        cyc(1);
        chk("fault Fault", 32'(Fault), 32'h1);
        chk("fault IFValid", 32'(IFValid), 32'h0);
        chk("fault IAddr hold", IAddr, 32'h80);
        RedirectValid = 1'b1;
        RedirectAddr  = 32'h0;
        cyc(2);
        RedirectValid = 1'b0;
        chk("fault frozen IAddr", IAddr, 32'h80);
        chk("fault frozen cnt", FetchCount, 32'd2);
        Reset = 1'b1;
        cyc(1);
        chk("recov Fault", 32'(Fault), 32'h0);
        chk("recov IAddr", IAddr, 32'h0);
        chk("recov FetchCount", FetchCount, 32'h0);
        Reset = 1'b0;
        cyc(2);
        chk("recov run IR", IR, 32'h0400_0011);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
